rob_flush_queue: RTL and testbench

//   Parametrised reorder buffer: in-order allocation from ID, out-of-order completion from NCDB

---
 rtl/rob_flush_queue_pkg.sv | 12 +
 rtl/rob_flush_queue_if.sv | 42 ++++
 rtl/rob_flush_queue_cdb_select.sv | 35 +++
 rtl/rob_flush_queue.sv | 147 ++++++++++++++
 tb/tb_rob_flush_queue.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rob_flush_queue_pkg.sv
// rob_flush_queue_pkg: shared defaults and instruction class codes for the reorder buffer
package rob_flush_queue_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDW = 4;
    localparam int ROB_NCDB = 2;
    localparam int REGW_D = 5;
    typedef enum logic [2:0] {
        INST_OTHER = 3'd0,
        INST_ST    = 3'd1,
        INST_BR    = 3'd2
    } inst_t;
endpackage

// File: rtl/rob_flush_queue_if.sv
// rob_flush_queue_if: bundle between ID/CDB/LSB producers (master) and the reorder buffer (slave)
//   master drives: rdy, alloc_*, cdb_*, st_rdy_*
//   slave drives : alloc_ready, alloc_id, cmt_*, cmt_st_*, flush_*, occupancy
interface rob_flush_queue_if import rob_flush_queue_pkg::*; #(
    parameter int IDW  = ROB_IDW,
    parameter int NCDB = ROB_NCDB,
    parameter int REGW = REGW_D
);
    logic                 rdy;
    logic                 alloc_flag;
    logic [2:0]           alloc_type;
    logic [REGW-1:0]      alloc_des;
    logic [31:0]          alloc_prd_pc;
    logic                 alloc_ready;
    logic [IDW-1:0]       alloc_id;
    logic [NCDB-1:0]      cdb_flag;
    logic [NCDB*IDW-1:0]  cdb_rob_id;
    logic [NCDB*32-1:0]   cdb_val;
    logic [NCDB*32-1:0]   cdb_rel_pc;
    logic                 st_rdy_flag;
    logic [IDW-1:0]       st_rdy_rob_id;
    logic                 cmt_flag;
    logic [REGW-1:0]      cmt_des;
    logic [31:0]          cmt_val;
    logic                 cmt_st_flag;
    logic [IDW-1:0]       cmt_st_rob_id;
    logic                 flush_flag;
    logic [31:0]          flush_pc;
    logic [IDW:0]         occupancy;
    modport master (
        output rdy, alloc_flag, alloc_type, alloc_des, alloc_prd_pc,
               cdb_flag, cdb_rob_id, cdb_val, cdb_rel_pc, st_rdy_flag, st_rdy_rob_id,
        input  alloc_ready, alloc_id, cmt_flag, cmt_des, cmt_val,
               cmt_st_flag, cmt_st_rob_id, flush_flag, flush_pc, occupancy
    );
    modport slave (
        input  rdy, alloc_flag, alloc_type, alloc_des, alloc_prd_pc,
               cdb_flag, cdb_rob_id, cdb_val, cdb_rel_pc, st_rdy_flag, st_rdy_rob_id,
        output alloc_ready, alloc_id, cmt_flag, cmt_des, cmt_val,
               cmt_st_flag, cmt_st_rob_id, flush_flag, flush_pc, occupancy
    );
endinterface

// File: rtl/rob_flush_queue_cdb_select.sv
// rob_flush_queue_cdb_select: matches one entry id against all CDB lanes, highest lane wins
//   i_id, i_cdb_* : entry id and broadcast lanes
//   o_hit, o_val, o_rel_pc : any lane hit and the winning lane's payload
//   o_rel_pc/i_cdb_rel_pc exist only with ROB_FLUSH_EN
module rob_flush_queue_cdb_select import rob_flush_queue_pkg::*; #(
    parameter int IDW  = ROB_IDW,
    parameter int NCDB = ROB_NCDB
) (
    input  logic [IDW-1:0]      i_id,
    input  logic [NCDB-1:0]     i_cdb_flag,
    input  logic [NCDB*IDW-1:0] i_cdb_rob_id,
    input  logic [NCDB*32-1:0]  i_cdb_val,
`ifdef ROB_FLUSH_EN
    input  logic [NCDB*32-1:0]  i_cdb_rel_pc,
    output logic [31:0]         o_rel_pc,
`endif
    output logic                o_hit,
    output logic [31:0]         o_val
);
    always_comb begin
        o_hit = 1'b0;
        o_val = '0;
`ifdef ROB_FLUSH_EN
        o_rel_pc = '0;
`endif
        for (int k = 0; k < NCDB; k++)
            if (i_cdb_flag[k] && i_cdb_rob_id[k*IDW +: IDW] == i_id) begin
                o_hit = 1'b1;
                o_val = i_cdb_val[k*32 +: 32];
`ifdef ROB_FLUSH_EN
                o_rel_pc = i_cdb_rel_pc[k*32 +: 32];
`endif
            end
    end
endmodule

// File: rtl/rob_flush_queue.sv
// rob_flush_queue: reorder buffer, in-order alloc, out-of-order completion, in-order commit
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rob_flush_queue_if.slave (alloc, CDB/store completion, commit, flush, occupancy)
//   ROB_FLUSH_EN : enables branch-mispredict flush at commit
module rob_flush_queue import rob_flush_queue_pkg::*; #(
    parameter int DEPTH = ROB_DEPTH,
    parameter int IDW   = ROB_IDW,
    parameter int NCDB  = ROB_NCDB,
    parameter int REGW  = REGW_D
) (
    input logic              clk,
    input logic              rst,
    rob_flush_queue_if.slave bus
);
    logic [IDW:0]      r_head, r_tail, r_occ;
    logic [DEPTH-1:0]  r_busy, r_ready;
    logic [2:0]        r_type [DEPTH];
    logic [REGW-1:0]   r_des [DEPTH];
    logic [31:0]       r_val [DEPTH];
    logic              r_cmt_flag, r_cmt_st_flag;
    logic [REGW-1:0]   r_cmt_des;
    logic [31:0]       r_cmt_val;
    logic [IDW-1:0]    r_cmt_st_rob_id;
    logic [DEPTH-1:0]  w_hit;
    logic [31:0]       w_cval [DEPTH];
    logic [IDW-1:0]    w_hidx, w_tidx;
    logic              w_empty, w_full, w_commit, w_alloc, w_is_st, w_flush;
    assign w_hidx   = r_head[IDW-1:0];
    assign w_tidx   = r_tail[IDW-1:0];
    assign w_empty  = r_head == r_tail;
    assign w_full   = w_hidx == w_tidx && r_head[IDW] != r_tail[IDW];
    assign w_commit = !w_empty && r_ready[w_hidx] && bus.rdy;
    assign w_alloc  = bus.alloc_flag && bus.alloc_ready && bus.rdy;
    assign w_is_st  = r_type[w_hidx] == INST_ST;
    assign bus.alloc_ready   = !w_full || w_commit;
    assign bus.alloc_id      = w_tidx;
    assign bus.occupancy     = r_occ;
    assign bus.cmt_flag      = r_cmt_flag;
    assign bus.cmt_des       = r_cmt_des;
    assign bus.cmt_val       = r_cmt_val;
    assign bus.cmt_st_flag   = r_cmt_st_flag;
    assign bus.cmt_st_rob_id = r_cmt_st_rob_id;
`ifdef ROB_FLUSH_EN
    logic [31:0] r_prd_pc [DEPTH];
    logic [31:0] r_rel_pc [DEPTH];
    logic [31:0] w_crel [DEPTH];
    logic        r_flush_flag;
    logic [31:0] r_flush_pc;
    assign w_flush = w_commit && r_type[w_hidx] == INST_BR && r_rel_pc[w_hidx] != r_prd_pc[w_hidx];
    assign bus.flush_flag = r_flush_flag;
    assign bus.flush_pc   = r_flush_pc;
`else
    logic w_unused;
    assign w_unused = ^{bus.alloc_prd_pc, bus.cdb_rel_pc};
    assign w_flush = 1'b0;
    assign bus.flush_flag = 1'b0;
    assign bus.flush_pc   = '0;
`endif
    for (genvar e = 0; e < DEPTH; e++) begin : g_sel
        rob_flush_queue_cdb_select #(.IDW(IDW), .NCDB(NCDB)) u_sel (
            .i_id         (IDW'(e)),
            .i_cdb_flag   (bus.cdb_flag),
            .i_cdb_rob_id (bus.cdb_rob_id),
            .i_cdb_val    (bus.cdb_val),
`ifdef ROB_FLUSH_EN
            .i_cdb_rel_pc (bus.cdb_rel_pc),
            .o_rel_pc     (w_crel[e]),
`endif
            .o_hit        (w_hit[e]),
            .o_val        (w_cval[e])
        );
    end
    // Ordering below: completions, then commit frees head, then alloc, so a
    // full-with-commit alloc reclaims the head slot and beats any completion to it.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ <= '0;
            r_busy <= '0;
            r_ready <= '0;
            r_cmt_flag <= 1'b0;
            r_cmt_st_flag <= 1'b0;
            r_cmt_des <= '0;
            r_cmt_val <= '0;
            r_cmt_st_rob_id <= '0;
`ifdef ROB_FLUSH_EN
            r_flush_flag <= 1'b0;
            r_flush_pc <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                r_type[i] <= '0;
                r_des[i] <= '0;
                r_val[i] <= '0;
`ifdef ROB_FLUSH_EN
                r_prd_pc[i] <= '0;
                r_rel_pc[i] <= '0;
`endif
            end
        end else if (bus.rdy) begin
            r_cmt_flag <= w_commit && !w_is_st;
            r_cmt_st_flag <= w_commit && w_is_st;
            if (w_commit && w_is_st) r_cmt_st_rob_id <= w_hidx;
            if (w_commit && !w_is_st) begin
                r_cmt_des <= r_des[w_hidx];
                r_cmt_val <= r_val[w_hidx];
            end
`ifdef ROB_FLUSH_EN
            r_flush_flag <= w_flush;
            if (w_flush) r_flush_pc <= r_rel_pc[w_hidx];
`endif
            if (w_flush) begin
                r_head <= '0;
                r_tail <= '0;
                r_occ <= '0;
                r_busy <= '0;
                r_ready <= '0;
            end else begin
                r_head <= r_head + (IDW+1)'(w_commit);
                r_tail <= r_tail + (IDW+1)'(w_alloc);
                r_occ <= r_occ + (IDW+1)'(w_alloc) - (IDW+1)'(w_commit);
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_busy[i] && w_hit[i]) begin
                        r_val[i] <= w_cval[i];
`ifdef ROB_FLUSH_EN
                        r_rel_pc[i] <= w_crel[i];
`endif
                        r_ready[i] <= 1'b1;
                    end
                    if (r_busy[i] && bus.st_rdy_flag && bus.st_rdy_rob_id == IDW'(i)) r_ready[i] <= 1'b1;
                end
                if (w_commit) begin
                    r_busy[w_hidx] <= 1'b0;
                    r_ready[w_hidx] <= 1'b0;
                end
                if (w_alloc) begin
                    r_busy[w_tidx] <= 1'b1;
                    r_ready[w_tidx] <= 1'b0;
                    r_type[w_tidx] <= bus.alloc_type;
                    r_des[w_tidx] <= bus.alloc_des;
`ifdef ROB_FLUSH_EN
                    r_prd_pc[w_tidx] <= bus.alloc_prd_pc;
`endif
                end
            end
        end
endmodule

// File: tb/tb_rob_flush_queue.sv
// tb_rob_flush_queue: directed self-checking bench for rob_flush_queue
module tb_rob_flush_queue;
    import rob_flush_queue_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int pass_cnt = 0;
    int total = 0;
    always #5 clk = ~clk;
    rob_flush_queue_if #(.IDW(4), .NCDB(2), .REGW(5)) bus ();
    rob_flush_queue #(.DEPTH(16), .IDW(4), .NCDB(2), .REGW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic idle();
        bus.rdy = 1'b1;
        bus.alloc_flag = 1'b0;
        bus.alloc_type = 3'd0;
        bus.alloc_des = 5'd0;
        bus.alloc_prd_pc = 32'd0;
        bus.cdb_flag = 2'b00;
        bus.cdb_rob_id = 8'd0;
        bus.cdb_val = 64'd0;
        bus.cdb_rel_pc = 64'd0;
        bus.st_rdy_flag = 1'b0;
        bus.st_rdy_rob_id = 4'd0;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        bus.alloc_flag = 1'b0;
        bus.cdb_flag = 2'b00;
        bus.st_rdy_flag = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        step();
    endtask
    task automatic alloc(input logic [2:0] t, input logic [4:0] d, input logic [31:0] pc);
        bus.alloc_flag = 1'b1;
        bus.alloc_type = t;
        bus.alloc_des = d;
        bus.alloc_prd_pc = pc;
        step();
    endtask
    task automatic cdb(input int k, input logic [3:0] id, input logic [31:0] v, input logic [31:0] pc);
        bus.cdb_flag[k] = 1'b1;
        bus.cdb_rob_id[k*4 +: 4] = id;
        bus.cdb_val[k*32 +: 32] = v;
        bus.cdb_rel_pc[k*32 +: 32] = pc;
    endtask
    task automatic test_reset();
        do_reset();
        total++; if (bus.occupancy !== 5'd0) $display("FAIL reset_occ got %0d exp 0", bus.occupancy); else pass_cnt++;
        total++; if (bus.alloc_id !== 4'd0) $display("FAIL reset_id got %0d exp 0", bus.alloc_id); else pass_cnt++;
        total++; if (bus.alloc_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", bus.alloc_ready); else pass_cnt++;
        for (int i = 0; i < 5; i++) alloc(INST_OTHER, 5'(i + 1), 32'd0);
        total++; if (bus.occupancy !== 5'd5) $display("FAIL live_occ got %0d exp 5", bus.occupancy); else pass_cnt++;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        total++; if (bus.occupancy !== 5'd0) $display("FAIL midrst_occ got %0d exp 0", bus.occupancy); else pass_cnt++;
        total++; if (bus.alloc_id !== 4'd0) $display("FAIL midrst_id got %0d exp 0", bus.alloc_id); else pass_cnt++;
        total++; if ({bus.cmt_flag, bus.cmt_st_flag, bus.flush_flag} !== 3'b000) $display("FAIL midrst_pulses got %b exp 000", {bus.cmt_flag, bus.cmt_st_flag, bus.flush_flag}); else pass_cnt++;
    endtask
    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) alloc(INST_OTHER, 5'(i + 1), 32'd0);
        total++; if (bus.occupancy !== 5'd16) $display("FAIL full_occ got %0d exp 16", bus.occupancy); else pass_cnt++;
        total++; if (bus.alloc_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", bus.alloc_ready); else pass_cnt++;
        cdb(0, 4'd0, 32'h55, 32'd0);
        step();
        total++; if (bus.alloc_ready !== 1'b1) $display("FAIL full_cmt_ready got %b exp 1", bus.alloc_ready); else pass_cnt++;
        total++; if (bus.alloc_id !== 4'd0) $display("FAIL full_cmt_id got %0d exp 0", bus.alloc_id); else pass_cnt++;
        alloc(INST_OTHER, 5'd7, 32'd0);
        total++; if (bus.occupancy !== 5'd16) $display("FAIL reuse_occ got %0d exp 16", bus.occupancy); else pass_cnt++;
        total++; if (bus.cmt_flag !== 1'b1 || bus.cmt_val !== 32'h55 || bus.cmt_des !== 5'd1) $display("FAIL reuse_cmt got %b/%h/%0d exp 1/55/1", bus.cmt_flag, bus.cmt_val, bus.cmt_des); else pass_cnt++;
        total++; if (bus.alloc_ready !== 1'b0 || bus.alloc_id !== 4'd1) $display("FAIL reuse_full got %b/%0d exp 0/1", bus.alloc_ready, bus.alloc_id); else pass_cnt++;
    endtask
    task automatic test_ooo();
        do_reset();
        for (int i = 0; i < 3; i++) alloc(INST_OTHER, 5'(i + 1), 32'd0);
        cdb(0, 4'd2, 32'h30, 32'd0);
        step();
        cdb(0, 4'd1, 32'h20, 32'd0);
        step();
        cdb(0, 4'd0, 32'h10, 32'd0);
        step();
        total++; if (bus.cmt_flag !== 1'b0) $display("FAIL ooo_early got %b exp 0", bus.cmt_flag); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.cmt_flag !== 1'b1 || bus.cmt_des !== 5'(i + 1) || bus.cmt_val !== 32'h10 * (i + 1)) $display("FAIL ooo_cmt%0d got %b/%0d/%h exp 1/%0d/%h", i, bus.cmt_flag, bus.cmt_des, bus.cmt_val, i + 1, 32'h10 * (i + 1)); else pass_cnt++;
        end
        step();
        total++; if (bus.cmt_flag !== 1'b0 || bus.occupancy !== 5'd0) $display("FAIL ooo_drain got %b/%0d exp 0/0", bus.cmt_flag, bus.occupancy); else pass_cnt++;
    endtask
    task automatic test_lane_conflict();
        do_reset();
        for (int i = 0; i < 4; i++) alloc(INST_OTHER, 5'(i + 1), 32'd0);
        cdb(0, 4'd0, 32'h1, 32'd0);
        cdb(1, 4'd1, 32'h2, 32'd0);
        step();
        cdb(0, 4'd2, 32'h3, 32'd0);
        step();
        cdb(0, 4'd3, 32'hAA, 32'd0);
        cdb(1, 4'd3, 32'hBB, 32'd0);
        step();
        step();
        total++; if (bus.cmt_val !== 32'h3) $display("FAIL conflict_prev got %h exp 3", bus.cmt_val); else pass_cnt++;
        step();
        total++; if (bus.cmt_flag !== 1'b1 || bus.cmt_val !== 32'hBB || bus.cmt_des !== 5'd4) $display("FAIL conflict_val got %b/%h/%0d exp 1/bb/4", bus.cmt_flag, bus.cmt_val, bus.cmt_des); else pass_cnt++;
        cdb(0, 4'd5, 32'hEE, 32'd0);
        step();
        step();
        total++; if (bus.cmt_flag !== 1'b0 || bus.occupancy !== 5'd0 || bus.cmt_val !== 32'hBB) $display("FAIL nonbusy got %b/%0d/%h exp 0/0/bb", bus.cmt_flag, bus.occupancy, bus.cmt_val); else pass_cnt++;
    endtask
    task automatic test_store();
        do_reset();
        for (int i = 0; i < 4; i++) alloc(INST_OTHER, 5'(i + 1), 32'd0);
        alloc(INST_ST, 5'd0, 32'd0);
        cdb(0, 4'd0, 32'h1, 32'd0);
        cdb(1, 4'd1, 32'h2, 32'd0);
        step();
        cdb(0, 4'd2, 32'h3, 32'd0);
        cdb(1, 4'd3, 32'h4, 32'd0);
        step();
        bus.st_rdy_flag = 1'b1;
        bus.st_rdy_rob_id = 4'd4;
        step();
        step();
        step();
        total++; if (bus.cmt_flag !== 1'b1 || bus.cmt_st_flag !== 1'b0 || bus.cmt_val !== 32'h4) $display("FAIL st_before got %b/%b/%h exp 1/0/4", bus.cmt_flag, bus.cmt_st_flag, bus.cmt_val); else pass_cnt++;
        step();
        total++; if (bus.cmt_st_flag !== 1'b1 || bus.cmt_st_rob_id !== 4'd4 || bus.cmt_flag !== 1'b0) $display("FAIL st_commit got %b/%0d/%b exp 1/4/0", bus.cmt_st_flag, bus.cmt_st_rob_id, bus.cmt_flag); else pass_cnt++;
        step();
        total++; if (bus.cmt_st_flag !== 1'b0 || bus.occupancy !== 5'd0) $display("FAIL st_after got %b/%0d exp 0/0", bus.cmt_st_flag, bus.occupancy); else pass_cnt++;
    endtask
    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 36; n++) begin
            total++; if (bus.alloc_id !== 4'(n % 16)) $display("FAIL wrap_id%0d got %0d exp %0d", n, bus.alloc_id, n % 16); else pass_cnt++;
            alloc(INST_OTHER, 5'(n), 32'd0);
            cdb(1, 4'(n % 16), 32'h1000 + n, 32'd0);
            step();
            step();
            total++; if (bus.cmt_flag !== 1'b1 || bus.cmt_val !== 32'h1000 + n) $display("FAIL wrap_cmt%0d got %b/%h exp 1/%h", n, bus.cmt_flag, bus.cmt_val, 32'h1000 + n); else pass_cnt++;
        end
        total++; if (bus.occupancy !== 5'd0 || bus.alloc_id !== 4'd4) $display("FAIL wrap_end got %0d/%0d exp 0/4", bus.occupancy, bus.alloc_id); else pass_cnt++;
    endtask
    task automatic test_rdy_freeze();
        do_reset();
        alloc(INST_OTHER, 5'd3, 32'd0);
        cdb(0, 4'd0, 32'h42, 32'd0);
        step();
        bus.rdy = 1'b0;
        bus.alloc_flag = 1'b1;
        step();
        total++; if (bus.cmt_flag !== 1'b0 || bus.occupancy !== 5'd1 || bus.alloc_id !== 4'd1) $display("FAIL freeze got %b/%0d/%0d exp 0/1/1", bus.cmt_flag, bus.occupancy, bus.alloc_id); else pass_cnt++;
        bus.rdy = 1'b1;
        step();
        total++; if (bus.cmt_flag !== 1'b1 || bus.cmt_val !== 32'h42 || bus.occupancy !== 5'd0) $display("FAIL unfreeze got %b/%h/%0d exp 1/42/0", bus.cmt_flag, bus.cmt_val, bus.occupancy); else pass_cnt++;
        bus.rdy = 1'b0;
        step();
        total++; if (bus.cmt_flag !== 1'b1) $display("FAIL pulse_hold got %b exp 1", bus.cmt_flag); else pass_cnt++;
        bus.rdy = 1'b1;
        step();
        total++; if (bus.cmt_flag !== 1'b0) $display("FAIL pulse_drop got %b exp 0", bus.cmt_flag); else pass_cnt++;
    endtask
    task automatic test_flush();
        do_reset();
        alloc(INST_BR, 5'd9, 32'h100);
        for (int i = 0; i < 3; i++) alloc(INST_OTHER, 5'(i + 1), 32'd0);
        cdb(0, 4'd0, 32'h77, 32'h200);
        step();
        bus.alloc_flag = 1'b1;
        bus.alloc_type = INST_OTHER;
        bus.alloc_des = 5'd5;
        cdb(1, 4'd1, 32'h99, 32'd0);
        step();
        total++; if (bus.cmt_flag !== 1'b1 || bus.cmt_val !== 32'h77 || bus.cmt_des !== 5'd9) $display("FAIL br_cmt got %b/%h/%0d exp 1/77/9", bus.cmt_flag, bus.cmt_val, bus.cmt_des); else pass_cnt++;
`ifdef ROB_FLUSH_EN
        total++; if (bus.flush_flag !== 1'b1 || bus.flush_pc !== 32'h200) $display("FAIL flush got %b/%h exp 1/200", bus.flush_flag, bus.flush_pc); else pass_cnt++;
        total++; if (bus.occupancy !== 5'd0 || bus.alloc_id !== 4'd0) $display("FAIL flush_ptr got %0d/%0d exp 0/0", bus.occupancy, bus.alloc_id); else pass_cnt++;
        step();
        total++; if (bus.flush_flag !== 1'b0 || bus.cmt_flag !== 1'b0 || bus.occupancy !== 5'd0) $display("FAIL flush_after got %b/%b/%0d exp 0/0/0", bus.flush_flag, bus.cmt_flag, bus.occupancy); else pass_cnt++;
`else
        total++; if (bus.flush_flag !== 1'b0 || bus.flush_pc !== 32'd0) $display("FAIL noflush got %b/%h exp 0/0", bus.flush_flag, bus.flush_pc); else pass_cnt++;
        total++; if (bus.occupancy !== 5'd4 || bus.alloc_id !== 4'd5) $display("FAIL noflush_ptr got %0d/%0d exp 4/5", bus.occupancy, bus.alloc_id); else pass_cnt++;
        step();
        total++; if (bus.cmt_flag !== 1'b1 || bus.cmt_val !== 32'h99 || bus.cmt_des !== 5'd1) $display("FAIL noflush_next got %b/%h/%0d exp 1/99/1", bus.cmt_flag, bus.cmt_val, bus.cmt_des); else pass_cnt++;
`endif
    endtask
    initial begin
        idle();
        test_reset();
        test_fill();
        test_ooo();
        test_lane_conflict();
        test_store();
        test_wrap();
        test_rdy_freeze();
        test_flush();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
